// File: rtl/idli_pkg.sv
// Shared types and helpers for the idli serial core control blocks.
package idli_pkg;

  // Slot-level sequencer states.
  typedef enum logic [1:0] {
    REDIR_ISSUE,
    REDIR_WAIT,
    STEADY,
    STALL
  } seq_state_t;

  // Default number of bits processed per cycle.
  localparam int IDLI_SER_W = 4;

  // Number of serial beats needed to cover one operand.
  function automatic int beats(input int data_w, input int ser_w);
    return data_w / ser_w;
  endfunction

endpackage

// File: rtl/idli_beat_ctr_m.sv
// Wrap-at-N beat counter with first/last beat flags.
// N need not be a power of two; the wrap is explicit.
module idli_beat_ctr_m #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [W-1:0] o_ctr,
  output logic         o_first,
  output logic         o_last
);

  localparam logic [W-1:0] LAST_VAL = W'(N - 1);

  logic [W-1:0] ctr_q;
  logic [W-1:0] ctr_d;

  if (N < 2) begin : g_chk_n
    $error("idli_beat_ctr_m: N must be at least 2");
  end

  // Next beat: advance by one, returning to zero after the last beat.
  always_comb begin
    ctr_d = (ctr_q == LAST_VAL) ? '0 : ctr_q + W'(1);
  end

  // Beat register, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign o_ctr   = ctr_q;
  assign o_first = (ctr_q == '0);
  assign o_last  = (ctr_q == LAST_VAL);

endmodule

// File: rtl/idli_seq_ctrl_m.sv
// Core sequencer: serial beat counter, redirect issue/wait sequencing,
// execute-driven redirects and stalls. Every slot-level decision is taken
// on the last beat of a slot; outputs depend on registered state only.
//
// Handshake note: i_seq_redirect is a one-cycle pulse that is always
// accepted (it is latched in pend_q until the next slot boundary acts on
// it); i_seq_stall is a level that is only looked at on slot boundaries.
module idli_seq_ctrl_m
  import idli_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SER_W         = IDLI_SER_W,
  parameter int REDIRECT_WAIT = 3,
  localparam int BEATS        = beats(DATA_W, SER_W),
  localparam int CTR_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             i_seq_gck,
  input  logic             i_seq_rst,
  input  logic             i_seq_redirect,
  input  logic             i_seq_stall,
  output logic [CTR_W-1:0] o_seq_ctr,
  output logic             o_seq_ctr_first_cycle,
  output logic             o_seq_ctr_last_cycle,
  output logic             o_seq_sqi_redirect,
  output logic             o_seq_dcd_enc_vld,
  output logic             o_seq_busy,
  output seq_state_t       o_seq_state
);

  localparam int WAIT_W = (REDIRECT_WAIT > 1) ? $clog2(REDIRECT_WAIT) : 1;
  // Value loaded on leaving the issue slot; the wait slot with wait_q==0 is the last one.
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    WAIT_W'((REDIRECT_WAIT > 0) ? REDIRECT_WAIT - 1 : 0);

  if (DATA_W % SER_W != 0) begin : g_chk_div
    $error("idli_seq_ctrl_m: DATA_W must be a multiple of SER_W");
  end
  if (BEATS < 2) begin : g_chk_beats
    $error("idli_seq_ctrl_m: DATA_W/SER_W must be at least 2");
  end

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  logic              pend_q;
  logic              pend_d;
  logic              redir_now;
  logic              slot_last;
  logic              sqi_redirect_q;
  logic              enc_vld_q;
  logic              busy_q;

  idli_beat_ctr_m #(
    .N (BEATS),
    .W (CTR_W)
  ) u_beat_ctr (
    .i_clk   (i_seq_gck),
    .i_rst   (i_seq_rst),
    .o_ctr   (o_seq_ctr),
    .o_first (o_seq_ctr_first_cycle),
    .o_last  (slot_last)
  );

  // Slot-boundary state transitions and redirect bookkeeping.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    redir_now = pend_q | i_seq_redirect;
    if (slot_last) begin
      unique case (state_q)
        REDIR_ISSUE: begin
          if (REDIRECT_WAIT == 0) begin
            state_d = STEADY;
          end else begin
            state_d = REDIR_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end
        REDIR_WAIT: begin
          if (redir_now) begin
            state_d = REDIR_ISSUE;
          end else if (wait_q == '0) begin
            state_d = STEADY;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        STEADY: begin
          if (redir_now) begin
            state_d = REDIR_ISSUE;
          end else if (i_seq_stall) begin
            state_d = STALL;
          end
        end
        STALL: begin
          if (redir_now) begin
            state_d = REDIR_ISSUE;
          end else if (!i_seq_stall) begin
            state_d = STEADY;
          end
        end
      endcase
    end
    // A new pulse always wins, so one landing on the boundary is kept for later.
    if (i_seq_redirect) begin
      pend_d = 1'b1;
    end else if (slot_last && state_d == REDIR_ISSUE) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // State, wait counter, pending redirect and decoded output flops.
  always_ff @(posedge i_seq_gck) begin
    if (i_seq_rst) begin
      state_q        <= REDIR_ISSUE;
      wait_q         <= '0;
      pend_q         <= 1'b0;
      sqi_redirect_q <= 1'b1;
      enc_vld_q      <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      pend_q         <= pend_d;
      sqi_redirect_q <= (state_d == REDIR_ISSUE);
      enc_vld_q      <= (state_d == STEADY);
      busy_q         <= (state_d != STEADY);
    end
  end

  assign o_seq_ctr_last_cycle = slot_last;
  assign o_seq_sqi_redirect   = sqi_redirect_q;
  assign o_seq_dcd_enc_vld    = enc_vld_q;
  assign o_seq_busy           = busy_q;
  assign o_seq_state          = state_q;

endmodule

// File: tb/tb_idli_seq_ctrl_m.sv
// Bench for idli_seq_ctrl_m: default instance checked against a slot-level
// reference model every cycle plus directed timing expectations; a second
// instance (12-bit, 4 per beat, no wait slots) checked with constants.
module tb_idli_seq_ctrl_m;
  import idli_pkg::*;

  localparam int BEATS_A = 4;
  localparam int RW_A    = 3;
  localparam int W       = 7;

  localparam int K_ISSUE  = 0;
  localparam int K_WAIT   = 1;
  localparam int K_STEADY = 2;
  localparam int K_STALL  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       redir_a = 1'b0;
  logic       stall_a = 1'b0;
  logic       redir_b = 1'b0;
  logic       stall_b = 1'b0;
  logic [1:0] ctr_a;
  logic       first_a, last_a, sqi_a, enc_a, busy_a;
  seq_state_t state_a;
  logic [1:0] ctr_b;
  logic       first_b, last_b, sqi_b, enc_b, busy_b;
  seq_state_t state_b;

  idli_seq_ctrl_m u_dut_a (
    .i_seq_gck             (clk),
    .i_seq_rst             (rst),
    .i_seq_redirect        (redir_a),
    .i_seq_stall           (stall_a),
    .o_seq_ctr             (ctr_a),
    .o_seq_ctr_first_cycle (first_a),
    .o_seq_ctr_last_cycle  (last_a),
    .o_seq_sqi_redirect    (sqi_a),
    .o_seq_dcd_enc_vld     (enc_a),
    .o_seq_busy            (busy_a),
    .o_seq_state           (state_a)
  );

  idli_seq_ctrl_m #(
    .DATA_W        (12),
    .SER_W         (4),
    .REDIRECT_WAIT (0)
  ) u_dut_b (
    .i_seq_gck             (clk),
    .i_seq_rst             (rst),
    .i_seq_redirect        (redir_b),
    .i_seq_stall           (stall_b),
    .o_seq_ctr             (ctr_b),
    .o_seq_ctr_first_cycle (first_b),
    .o_seq_ctr_last_cycle  (last_b),
    .o_seq_sqi_redirect    (sqi_b),
    .o_seq_dcd_enc_vld     (enc_b),
    .o_seq_busy            (busy_b),
    .o_seq_state           (state_b)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_a;
  logic [W-1:0] obs_b;
  seq_state_t   obs_state_a;
  int           n_tests = 0;
  int           n_fail  = 0;

  // ---------------- reference model (slot level) ----------------
  int m_cyc    = 0;  // cycles since reset; beat = m_cyc % BEATS_A
  int m_kind   = K_ISSUE;
  int m_waited = 0;  // which wait slot (1..RW_A) is in progress
  bit m_pend   = 1'b0;

  function automatic logic [W-1:0] model_vec();
    int         b;
    logic [1:0] bb;
    b  = m_cyc % BEATS_A;
    bb = 2'(b);
    return {bb, b == 0, b == BEATS_A - 1, m_kind == K_ISSUE,
            m_kind == K_STEADY, m_kind != K_STEADY};
  endfunction

  task automatic model_step(input logic r, input logic rd, input logic st);
    int nk;
    bit bnd;
    bit rn;
    if (r) begin
      m_cyc = 0; m_kind = K_ISSUE; m_waited = 0; m_pend = 1'b0;
    end else begin
      bnd = ((m_cyc % BEATS_A) == BEATS_A - 1);
      rn  = m_pend || rd;
      nk  = m_kind;
      if (bnd) begin
        case (m_kind)
          K_ISSUE: begin
            if (RW_A == 0) nk = K_STEADY;
            else begin nk = K_WAIT; m_waited = 1; end
          end
          K_WAIT: begin
            if (rn) nk = K_ISSUE;
            else if (m_waited == RW_A) nk = K_STEADY;
            else m_waited = m_waited + 1;
          end
          K_STEADY: begin
            if (rn) nk = K_ISSUE;
            else if (st) nk = K_STALL;
          end
          default: begin
            if (rn) nk = K_ISSUE;
            else if (!st) nk = K_STEADY;
          end
        endcase
      end
      if (rd) m_pend = 1'b1;
      else if (bnd && nk == K_ISSUE) m_pend = 1'b0;
      m_kind = nk;
      m_cyc  = m_cyc + 1;
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs for one cycle, sample at the falling edge, advance model.
  task automatic tick(input logic r, input logic rd, input logic st);
    rst = r; redir_a = rd; stall_a = st;
    @(negedge clk);
    obs_a       = {ctr_a, first_a, last_a, sqi_a, enc_a, busy_a};
    obs_b       = {ctr_b, first_b, last_b, sqi_b, enc_b, busy_b};
    obs_state_a = state_a;
    exp_q.push_back(model_vec());
    @(posedge clk);
    model_step(r, rd, st);
    #1;
  endtask

  // Advance with idle inputs until the model reaches a given slot and beat.
  task automatic go_to(input int kind, input int waited, input int beat, input logic st);
    logic [W-1:0] e;
    int k;
    k = 0;
    while (!(m_kind == kind && (waited < 0 || m_waited == waited) &&
             (m_cyc % BEATS_A) == beat) && k < 200) begin
      tick(1'b0, 1'b0, st);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_a !== e) begin
        n_fail++;
        $display("FAIL go_to_model: got %b want %b (t=%0t)", obs_a, e, $time);
      end
      k++;
    end
    if (k >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL go_to_timeout: kind %0d beat %0d not reached in 200 cycles", kind, beat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    logic [W-1:0] de;
    logic [1:0]   bb;
    tick(1'b1, 1'b0, 1'b0); e = exp_q.pop_front();
    tick(1'b1, 1'b0, 1'b0); e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      e  = exp_q.pop_front();
      bb = 2'(i % 4);
      de = {bb, (i % 4) == 0, (i % 4) == 3, i < 4, i >= 16, i < 16};
      n_tests++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL reset_model c%0d: got %b want %b", i, obs_a, e);
      end
      n_tests++;
      if (obs_a !== de) begin
        n_fail++; $display("FAIL reset_latency c%0d: got %b want %b", i, obs_a, de);
      end
      if (i == 0) begin
        n_tests++;
        if (obs_state_a !== REDIR_ISSUE) begin
          n_fail++; $display("FAIL reset_state: got %0d want %0d", obs_state_a, REDIR_ISSUE);
        end
      end
    end
  endtask

  task automatic test_no_wait();
    logic [W-1:0] e;
    logic [W-1:0] de;
    logic [1:0]   bb;
    tick(1'b1, 1'b0, 1'b0); e = exp_q.pop_front();
    for (int i = 0; i < 9; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      e  = exp_q.pop_front();
      bb = 2'(i % 3);
      de = {bb, (i % 3) == 0, (i % 3) == 2, i < 3, i >= 3, i < 3};
      n_tests++;
      if (obs_b !== de) begin
        n_fail++; $display("FAIL no_wait_b c%0d: got %b want %b", i, obs_b, de);
      end
      n_tests++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL no_wait_a_model c%0d: got %b want %b", i, obs_a, e);
      end
    end
  endtask

  task automatic test_redirect();
    logic [W-1:0] e;
    logic [1:0]   de2;
    go_to(K_STEADY, -1, 1, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    n_tests++;
    if (obs_a !== e) begin
      n_fail++; $display("FAIL redirect_pulse: got %b want %b", obs_a, e);
    end
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      e   = exp_q.pop_front();
      de2 = {j >= 2 && j < 6, j < 2 || j >= 18};
      n_tests++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL redirect_model j%0d: got %b want %b", j, obs_a, e);
      end
      n_tests++;
      if (obs_a[2:1] !== de2) begin
        n_fail++; $display("FAIL redirect_timing j%0d: sqi/enc got %b want %b", j, obs_a[2:1], de2);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    go_to(K_STEADY, -1, 0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      tick(1'b0, 1'b0, j < 8);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL stall_model j%0d: got %b want %b", j, obs_a, e);
      end
      n_tests++;
      if (obs_a[1] !== (j < 4 || j >= 12)) begin
        n_fail++; $display("FAIL stall_two_slots j%0d: enc got %b want %b", j, obs_a[1], (j < 4 || j >= 12));
      end
    end
    // A stall that drops before the boundary must be ignored.
    for (int j = 0; j < 8; j++) begin
      tick(1'b0, 1'b0, j == 1);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_a[1] !== 1'b1 || obs_a !== e) begin
        n_fail++; $display("FAIL stall_pulse j%0d: got %b want %b", j, obs_a, e);
      end
    end
  endtask

  task automatic test_redirect_in_wait();
    logic [W-1:0] e;
    logic [1:0]   de2;
    go_to(K_STEADY, -1, 0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    go_to(K_WAIT, 2, 1, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      e   = exp_q.pop_front();
      de2 = {j >= 2 && j < 6, j >= 18};
      n_tests++;
      if (obs_a !== e || obs_a[2:1] !== de2) begin
        n_fail++; $display("FAIL redirect_in_wait j%0d: got %b want %b (sqi/enc %b)", j, obs_a, e, de2);
      end
    end
    // Redirect while stalled with stall still high: redirect wins.
    go_to(K_STEADY, -1, 0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      tick(1'b0, 1'b0, 1'b1); e = exp_q.pop_front();
    end
    tick(1'b0, 1'b1, 1'b1); e = exp_q.pop_front();
    for (int j = 0; j < 6; j++) begin
      tick(1'b0, 1'b0, 1'b1);
      e   = exp_q.pop_front();
      de2 = {j >= 2, 1'b0};
      n_tests++;
      if (obs_a !== e || obs_a[2:1] !== de2) begin
        n_fail++; $display("FAIL redirect_over_stall j%0d: got %b want %b (sqi/enc %b)", j, obs_a, e, de2);
      end
    end
  endtask

  task automatic test_redirect_on_issue_boundary();
    logic [W-1:0] e;
    logic [1:0]   de2;
    go_to(K_STEADY, -1, 0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    go_to(K_ISSUE, -1, 3, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    for (int j = 0; j < 24; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      e   = exp_q.pop_front();
      de2 = {j >= 4 && j < 8, j >= 20};
      n_tests++;
      if (obs_a !== e || obs_a[2:1] !== de2) begin
        n_fail++; $display("FAIL issue_boundary j%0d: got %b want %b (sqi/enc %b)", j, obs_a, e, de2);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [W-1:0] e;
    logic [W-1:0] de;
    logic [1:0]   bb;
    go_to(K_STEADY, -1, 0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    go_to(K_WAIT, 2, 0, 1'b0);
    tick(1'b0, 1'b1, 1'b0); e = exp_q.pop_front();
    tick(1'b0, 1'b0, 1'b0); e = exp_q.pop_front();
    tick(1'b1, 1'b0, 1'b0); e = exp_q.pop_front();
    for (int j = 0; j < 20; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      e  = exp_q.pop_front();
      bb = 2'(j % 4);
      de = {bb, (j % 4) == 0, (j % 4) == 3, j < 4, j >= 16, j < 16};
      n_tests++;
      if (obs_a !== e || obs_a !== de) begin
        n_fail++; $display("FAIL reset_mid_wait j%0d: got %b want %b", j, obs_a, de);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    logic         r;
    logic         rd;
    logic         st;
    st = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      rd = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) st = ~st;
      tick(r, rd, st);
      e = exp_q.pop_front();
      n_tests++;
      if (obs_a !== e) begin
        n_fail++; $display("FAIL random c%0d: got %b want %b (r=%b rd=%b st=%b)", i, obs_a, e, r, rd, st);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_no_wait();
    test_redirect();
    test_stall();
    test_redirect_in_wait();
    test_redirect_on_issue_boundary();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
